// File: rtl/mem_seq_port_pkg.sv
// mem_seq_port_pkg
//   Shared definitions for the byte-serial memory port: transfer size
//   encodings carried on MS[1:0], the sequencer state type, and small
//   helpers for request validation and read-data extension.
package mem_seq_port_pkg;

    // Transfer size encodings on MS[1:0]
    localparam logic [1:0] MS_BYTE = 2'b00;
    localparam logic [1:0] MS_HALF = 2'b01;
    localparam logic [1:0] MS_WORD = 2'b10;
    localparam logic [1:0] MS_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_DONE
    } state_t;

    // Index of the final byte of a transfer (N-1).
    function automatic logic [1:0] lastByteIdx(input logic [1:0] size);
        case (size)
            MS_BYTE: return 2'd0;
            MS_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // A request is rejected when its size is reserved or its address is not
    // a multiple of the access size.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLow);
        case (size)
            MS_BYTE: return 1'b0;
            MS_HALF: return addrLow[0];
            MS_WORD: return addrLow != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Zero- or sign-extend the assembled read value from the access size.
    function automatic logic [31:0] extendRead(input logic [31:0] raw, input logic [1:0] size,
                                               input logic signExt);
        case (size)
            MS_BYTE: return {{24{signExt & raw[7]}}, raw[7:0]};
            MS_HALF: return {{16{signExt & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_seq_port_store.sv
// byte_store_256x8
//   Single-port byte store: synchronous write, combinational read.
//   The array is named memory so a bench can inspect it hierarchically.
// Ports
//   clk_i    rising-edge clock for writes
//   we_i     write enable
//   addr_i   byte address (read and write)
//   wdata_i  byte to write
//   rdata_o  byte currently stored at addr_i
module byte_store_256x8 #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] memory [0:2**ADDR_W-1];

    // Contents are deliberately not reset; only the sequencer's enable writes.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = memory[addr_i];

endmodule

// File: rtl/mem_seq_port.sv
// mem_seq_port
//   Byte-serial memory port between the datapath MAR/MDR and a byte store.
//   A MOV request is captured, optionally delayed by WAIT_STATES cycles, then
//   moved one byte per cycle in big-endian order. Completion is signalled on
//   MOC with a four-phase handshake.
// Ports
//   CLK        system clock
//   RESET      synchronous active-high reset
//   MOV        request from the control unit, held until MOC is seen
//   RW         1 = read, 0 = write
//   MS         [1:0] size (byte/half/word/reserved), [2] sign-extend reads
//   ADDR       byte address
//   DATA_IN    write data, byte/halfword in the low bits
//   DATA_OUT   extended read result, held until the next successful read
//   MOC        memory operation complete
//   ALIGN_ERR  request was misaligned or reserved size; valid with MOC
module mem_seq_port
    import mem_seq_port_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MOV,
    input  logic              RW,
    input  logic [2:0]        MS,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DATA_IN,
    output logic [31:0]       DATA_OUT,
    output logic              MOC,
    output logic              ALIGN_ERR
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic              rw_q, rw_d;
    logic [1:0]        byteIdx_q, byteIdx_d;
    logic [3:0]        waitCnt_q, waitCnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       dataOut_q, dataOut_d;
    logic              moc_q, moc_d;
    logic              alignErr_q, alignErr_d;

    logic              storeWe;
    logic [ADDR_W-1:0] storeAddr;
    logic [7:0]        storeWdata;
    logic [7:0]        storeRdata;
    logic [4:0]        wrShift;

    byte_store_256x8 #(.ADDR_W(ADDR_W)) u_store (
        .clk_i   (CLK),
        .we_i    (storeWe),
        .addr_i  (storeAddr),
        .wdata_i (storeWdata),
        .rdata_o (storeRdata)
    );

    // Next-state logic. MOC rises one cycle after DONE is entered, so DONE
    // can only be left once MOC has been visible; this gives a one-cycle MOC
    // pulse when MOV was already dropped during the transfer. The store write
    // is gated by RESET so an aborting edge never writes a further byte.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        size_d     = size_q;
        sign_d     = sign_q;
        rw_d       = rw_q;
        byteIdx_d  = byteIdx_q;
        waitCnt_d  = waitCnt_q;
        shift_d    = shift_q;
        dataOut_d  = dataOut_q;
        moc_d      = moc_q;
        alignErr_d = alignErr_q;
        storeWe    = 1'b0;
        storeAddr  = addr_q + ADDR_W'(byteIdx_q);
        wrShift    = {lastByteIdx(size_q) - byteIdx_q, 3'b000};
        storeWdata = 8'(data_q >> wrShift);

        case (state_q)
            ST_IDLE: begin
                if (MOV) begin
                    addr_d    = ADDR;
                    data_d    = DATA_IN;
                    size_d    = MS[1:0];
                    sign_d    = MS[2];
                    rw_d      = RW;
                    byteIdx_d = 2'd0;
                    shift_d   = '0;
                    if (isMisaligned(MS[1:0], ADDR[1:0])) begin
                        state_d    = ST_DONE;
                        alignErr_d = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d   = ST_WAIT;
                        waitCnt_d = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                waitCnt_d = waitCnt_q - 4'd1;
                if (waitCnt_q <= 4'd1) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                storeWe   = ~rw_q & ~RESET;
                shift_d   = {shift_q[15:0], storeRdata};
                byteIdx_d = byteIdx_q + 2'd1;
                if (byteIdx_q == lastByteIdx(size_q)) begin
                    state_d = ST_DONE;
                    if (rw_q) begin
                        dataOut_d = extendRead({shift_q, storeRdata}, size_q, sign_q);
                    end
                end
            end
            ST_DONE: begin
                if (!moc_q) begin
                    moc_d = 1'b1;
                end else if (!MOV) begin
                    state_d    = ST_IDLE;
                    moc_d      = 1'b0;
                    alignErr_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            rw_q       <= 1'b0;
            byteIdx_q  <= '0;
            waitCnt_q  <= '0;
            shift_q    <= '0;
            dataOut_q  <= '0;
            moc_q      <= 1'b0;
            alignErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            rw_q       <= rw_d;
            byteIdx_q  <= byteIdx_d;
            waitCnt_q  <= waitCnt_d;
            shift_q    <= shift_d;
            dataOut_q  <= dataOut_d;
            moc_q      <= moc_d;
            alignErr_q <= alignErr_d;
        end
    end

    assign DATA_OUT  = dataOut_q;
    assign MOC       = moc_q;
    assign ALIGN_ERR = alignErr_q;

endmodule

// File: tb/tb_mem_seq_port.sv
// tb_mem_seq_port
//   Self-checking bench for mem_seq_port with WAIT_STATES=1. A table of
//   requests is applied in order (memory contents carry over between rows);
//   expected completions are queued when a request is driven and compared
//   when MOC rises. Hand-written sequences cover early MOV release and reset
//   in the middle of a word write.
module tb_mem_seq_port;
    import mem_seq_port_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MOV;
    logic        RW;
    logic [2:0]  MS;
    logic [7:0]  ADDR;
    logic [31:0] DATA_IN;
    logic [31:0] DATA_OUT;
    logic        MOC;
    logic        ALIGN_ERR;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rw;
        logic [2:0]  ms;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] expOut;
        logic        expErr;
        int          expLat;
    } vec_t;

    typedef struct {
        logic [31:0] dataOut;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs [16];
    exp_t sbQ [$];

    mem_seq_port #(.WAIT_STATES(1), .ADDR_W(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MOV       (MOV),
        .RW        (RW),
        .MS        (MS),
        .ADDR      (ADDR),
        .DATA_IN   (DATA_IN),
        .DATA_OUT  (DATA_OUT),
        .MOC       (MOC),
        .ALIGN_ERR (ALIGN_ERR)
    );

    // 10 ns clock
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request at the falling edge and queue its expected completion.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge CLK);
        RW      = v.rw;
        MS      = v.ms;
        ADDR    = v.addr;
        DATA_IN = v.data;
        MOV     = 1'b1;
        e.dataOut = v.expOut;
        e.err     = v.expErr;
        e.lat     = v.expLat;
        sbQ.push_back(e);
    endtask

    // Wait for MOC (bounded), compare against the queued expectation, then
    // complete the handshake. Inputs are scrambled after capture to show the
    // operation uses only latched values.
    task automatic checkOutput(input string name, input bit dropEarly);
        int   cnt;
        exp_t e;
        @(posedge CLK);
        #1;
        cnt     = 0;
        ADDR    = 8'($urandom);
        DATA_IN = $urandom;
        MS      = 3'($urandom);
        RW      = 1'($urandom);
        if (dropEarly) MOV = 1'b0;
        while (!MOC && cnt < 60) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        if (sbQ.size() == 0) begin
            check({name, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = sbQ.pop_front();
        check({name, "_latency"}, 32'(cnt), 32'(e.lat));
        check({name, "_dataout"}, DATA_OUT, e.dataOut);
        check({name, "_alignerr"}, {31'd0, ALIGN_ERR}, {31'd0, e.err});
        if (!dropEarly) begin
            repeat (2) @(posedge CLK);
            #1;
            check({name, "_moc_held"}, {31'd0, MOC}, 32'd1);
            @(negedge CLK);
            MOV = 1'b0;
        end
        @(posedge CLK);
        #1;
        check({name, "_moc_release"}, {31'd0, MOC}, 32'd0);
        check({name, "_err_release"}, {31'd0, ALIGN_ERR}, 32'd0);
    endtask

    task automatic runVec(input string name, input vec_t v, input bit dropEarly);
        applyStimulus(v);
        checkOutput(name, dropEarly);
    endtask

    task automatic checkMem(input logic [7:0] addr, input logic [7:0] exp);
        check($sformatf("mem_%02h", addr), {24'd0, dut.u_store.memory[addr]}, {24'd0, exp});
    endtask

    initial begin
        vec_t v;
        // rw, ms, addr, data, expected DATA_OUT, expected ALIGN_ERR, latency
        vecs[0]  = '{1'b0, 3'b010, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 6};
        vecs[1]  = '{1'b0, 3'b000, 8'h13, 32'h1234568F, 32'h00000000, 1'b0, 3};
        vecs[2]  = '{1'b1, 3'b100, 8'h13, 32'h0,        32'hFFFFFF8F, 1'b0, 3};
        vecs[3]  = '{1'b1, 3'b000, 8'h13, 32'h0,        32'h0000008F, 1'b0, 3};
        vecs[4]  = '{1'b0, 3'b000, 8'h13, 32'h000000EF, 32'h0000008F, 1'b0, 3};
        vecs[5]  = '{1'b1, 3'b101, 8'h12, 32'h0,        32'hFFFFBEEF, 1'b0, 4};
        vecs[6]  = '{1'b1, 3'b001, 8'h12, 32'h0,        32'h0000BEEF, 1'b0, 4};
        vecs[7]  = '{1'b1, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 6};
        vecs[8]  = '{1'b0, 3'b010, 8'h20, 32'h11223344, 32'hDEADBEEF, 1'b0, 6};
        vecs[9]  = '{1'b0, 3'b010, 8'h21, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1, 1};
        vecs[10] = '{1'b1, 3'b101, 8'h11, 32'h0,        32'hDEADBEEF, 1'b1, 1};
        vecs[11] = '{1'b1, 3'b011, 8'h20, 32'h0,        32'hDEADBEEF, 1'b1, 1};
        vecs[12] = '{1'b0, 3'b001, 8'h30, 32'hCAFE1234, 32'hDEADBEEF, 1'b0, 4};
        vecs[13] = '{1'b1, 3'b101, 8'h30, 32'h0,        32'h00001234, 1'b0, 4};
        vecs[14] = '{1'b1, 3'b100, 8'h10, 32'h0,        32'hFFFFFFDE, 1'b0, 3};
        vecs[15] = '{1'b1, 3'b110, 8'h20, 32'h0,        32'h11223344, 1'b0, 6};

        RESET = 1'b1; MOV = 1'b0; RW = 1'b0; MS = 3'b000; ADDR = 8'h00; DATA_IN = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_moc", {31'd0, MOC}, 32'd0);
        check("reset_alignerr", {31'd0, ALIGN_ERR}, 32'd0);
        check("reset_dataout", DATA_OUT, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 16; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // MOV released one cycle into a word write: transfer completes, MOC pulses once
        v = '{1'b0, 3'b010, 8'h40, 32'hA1B2C3D4, 32'h11223344, 1'b0, 6};
        runVec("drop_early", v, 1'b1);

        // Reset after the second byte of a word write
        v = '{1'b0, 3'b010, 8'h50, 32'h99AABBCC, 32'h11223344, 1'b0, 6};
        runVec("pre_reset_fill", v, 1'b0);
        @(negedge CLK);
        RW = 1'b0; MS = 3'b010; ADDR = 8'h50; DATA_IN = 32'h55667788; MOV = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        MOV   = 1'b0;
        @(posedge CLK);
        #1;
        check("midreset_moc", {31'd0, MOC}, 32'd0);
        check("midreset_dataout", DATA_OUT, 32'h0);
        check("midreset_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        v = '{1'b1, 3'b000, 8'h51, 32'h0, 32'h00000066, 1'b0, 3};
        runVec("post_reset_read", v, 1'b0);

        checkMem(8'h10, 8'hDE); checkMem(8'h11, 8'hAD);
        checkMem(8'h12, 8'hBE); checkMem(8'h13, 8'hEF);
        checkMem(8'h20, 8'h11); checkMem(8'h21, 8'h22);
        checkMem(8'h22, 8'h33); checkMem(8'h23, 8'h44);
        checkMem(8'h30, 8'h12); checkMem(8'h31, 8'h34);
        checkMem(8'h40, 8'hA1); checkMem(8'h41, 8'hB2);
        checkMem(8'h42, 8'hC3); checkMem(8'h43, 8'hD4);
        checkMem(8'h50, 8'h55); checkMem(8'h51, 8'h66);
        checkMem(8'h52, 8'hBB); checkMem(8'h53, 8'hCC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
